// File: rtl/id_ex_alu_ctrl.sv
// ID/EX pipeline register with RV32I decode into ALU control and operands.
// Decode is purely combinational. Registers update with priority rst > flush > stall > load.

`ifndef ALU_OP_WIDTH
`define ALU_OP_WIDTH     4
`define ALU_OP_ADD       4'd0
`define ALU_OP_SUB       4'd1
`define ALU_OP_SLL       4'd2
`define ALU_OP_SLT       4'd3
`define ALU_OP_SLTU      4'd4
`define ALU_OP_XOR       4'd5
`define ALU_OP_SRL       4'd6
`define ALU_OP_SRA       4'd7
`define ALU_OP_OR        4'd8
`define ALU_OP_AND       4'd9
`define ALU_OP_COPY_SRC2 4'd10
`endif

module id_ex_alu_ctrl #(
    parameter int XLEN         = 32,
    parameter int ALU_OP_WIDTH = `ALU_OP_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    id_valid,
    input  logic [31:0]             id_instr,
    input  logic [XLEN-1:0]         id_pc,
    input  logic [XLEN-1:0]         id_rs1_data,
    input  logic [XLEN-1:0]         id_rs2_data,
    input  logic                    stall,
    input  logic                    flush,
    output logic                    ex_valid,
    output logic [ALU_OP_WIDTH-1:0] ex_alu_op,
    output logic [XLEN-1:0]         ex_src1,
    output logic [XLEN-1:0]         ex_src2,
    output logic [4:0]              ex_rd,
    output logic                    ex_reg_write,
    output logic                    ex_illegal
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rd;

    assign opcode = id_instr[6:0];
    assign funct3 = id_instr[14:12];
    assign funct7 = id_instr[31:25];
    assign rd     = id_instr[11:7];

    logic [XLEN-1:0] imm_i, imm_s, imm_u;

    assign imm_i = XLEN'($signed(id_instr[31:20]));
    assign imm_s = XLEN'($signed({id_instr[31:25], id_instr[11:7]}));
    assign imm_u = XLEN'($signed({id_instr[31:12], 12'b0}));

    logic [ALU_OP_WIDTH-1:0] dec_op;
    logic [XLEN-1:0]         dec_src1, dec_src2;
    logic                    dec_writes, dec_illegal;
    logic [ALU_OP_WIDTH-1:0] f3_op;

    // Base ALU operation selected by funct3 (shared by R-type and I-type ALU forms)
    always_comb begin
        f3_op = `ALU_OP_ADD;
        case (funct3)
            3'b000: f3_op = `ALU_OP_ADD;
            3'b001: f3_op = `ALU_OP_SLL;
            3'b010: f3_op = `ALU_OP_SLT;
            3'b011: f3_op = `ALU_OP_SLTU;
            3'b100: f3_op = `ALU_OP_XOR;
            3'b101: f3_op = `ALU_OP_SRL;
            3'b110: f3_op = `ALU_OP_OR;
            default: f3_op = `ALU_OP_AND;
        endcase
    end

    // Instruction decode: operation, operand selection, write-enable and legality
    always_comb begin
        dec_op      = `ALU_OP_ADD;
        dec_src1    = '0;
        dec_src2    = '0;
        dec_writes  = 1'b1;
        dec_illegal = 1'b0;
        case (opcode)
            7'b0110011: begin
                dec_src1 = id_rs1_data;
                dec_src2 = id_rs2_data;
                if (funct7 == 7'b0000000) begin
                    dec_op = f3_op;
                end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
                    dec_op = `ALU_OP_SUB;
                end else if (funct7 == 7'b0100000 && funct3 == 3'b101) begin
                    dec_op = `ALU_OP_SRA;
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            7'b0010011: begin
                dec_src1 = id_rs1_data;
                dec_src2 = imm_i;
                dec_op   = f3_op;
                if (funct3 == 3'b001 && funct7 != 7'b0000000) begin
                    dec_illegal = 1'b1;
                end else if (funct3 == 3'b101) begin
                    if (funct7 == 7'b0100000) begin
                        dec_op = `ALU_OP_SRA;
                    end else if (funct7 != 7'b0000000) begin
                        dec_illegal = 1'b1;
                    end
                end
            end
            7'b0110111: begin
                dec_op   = `ALU_OP_COPY_SRC2;
                dec_src2 = imm_u;
            end
            7'b0010111: begin
                dec_src1 = id_pc;
                dec_src2 = imm_u;
            end
            7'b1101111, 7'b1100111: begin
                dec_src1 = id_pc;
                dec_src2 = XLEN'(4);
            end
            7'b0000011: begin
                dec_src1 = id_rs1_data;
                dec_src2 = imm_i;
            end
            7'b0100011: begin
                dec_src1   = id_rs1_data;
                dec_src2   = imm_s;
                dec_writes = 1'b0;
            end
            7'b1100011: begin
                dec_src1   = id_rs1_data;
                dec_src2   = id_rs2_data;
                dec_writes = 1'b0;
                case (funct3)
                    3'b000, 3'b001: dec_op = `ALU_OP_SUB;
                    3'b100, 3'b101: dec_op = `ALU_OP_SLT;
                    3'b110, 3'b111: dec_op = `ALU_OP_SLTU;
                    default:        dec_illegal = 1'b1;
                endcase
            end
            default: dec_illegal = 1'b1;
        endcase
        if (dec_illegal) begin
            dec_op     = `ALU_OP_ADD;
            dec_src1   = '0;
            dec_src2   = '0;
            dec_writes = 1'b0;
        end
    end

    logic                    valid_q, valid_d;
    logic [ALU_OP_WIDTH-1:0] alu_op_q, alu_op_d;
    logic [XLEN-1:0]         src1_q, src1_d;
    logic [XLEN-1:0]         src2_q, src2_d;
    logic [4:0]              rd_q, rd_d;
    logic                    reg_write_q, reg_write_d;
    logic                    illegal_q, illegal_d;

    // Next EX state: flush inserts a bubble, stall holds, otherwise load decode or bubble
    always_comb begin
        valid_d     = 1'b0;
        alu_op_d    = `ALU_OP_ADD;
        src1_d      = '0;
        src2_d      = '0;
        rd_d        = '0;
        reg_write_d = 1'b0;
        illegal_d   = 1'b0;
        if (!flush && stall) begin
            valid_d     = valid_q;
            alu_op_d    = alu_op_q;
            src1_d      = src1_q;
            src2_d      = src2_q;
            rd_d        = rd_q;
            reg_write_d = reg_write_q;
            illegal_d   = illegal_q;
        end else if (!flush && id_valid) begin
            valid_d     = 1'b1;
            alu_op_d    = dec_op;
            src1_d      = dec_src1;
            src2_d      = dec_src2;
            rd_d        = rd;
            reg_write_d = dec_writes && (rd != 5'd0);
            illegal_d   = dec_illegal;
        end
    end

    // EX stage registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q     <= 1'b0;
            alu_op_q    <= `ALU_OP_ADD;
            src1_q      <= '0;
            src2_q      <= '0;
            rd_q        <= '0;
            reg_write_q <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            alu_op_q    <= alu_op_d;
            src1_q      <= src1_d;
            src2_q      <= src2_d;
            rd_q        <= rd_d;
            reg_write_q <= reg_write_d;
            illegal_q   <= illegal_d;
        end
    end

    assign ex_valid     = valid_q;
    assign ex_alu_op    = alu_op_q;
    assign ex_src1      = src1_q;
    assign ex_src2      = src2_q;
    assign ex_rd        = rd_q;
    assign ex_reg_write = reg_write_q;
    assign ex_illegal   = illegal_q;

endmodule

// File: tb/tb_id_ex_alu_ctrl.sv
// Testbench for id_ex_alu_ctrl: directed cases plus randomized traffic against a reference model.

`ifndef ALU_OP_WIDTH
`define ALU_OP_WIDTH     4
`define ALU_OP_ADD       4'd0
`define ALU_OP_SUB       4'd1
`define ALU_OP_SLL       4'd2
`define ALU_OP_SLT       4'd3
`define ALU_OP_SLTU      4'd4
`define ALU_OP_XOR       4'd5
`define ALU_OP_SRL       4'd6
`define ALU_OP_SRA       4'd7
`define ALU_OP_OR        4'd8
`define ALU_OP_AND       4'd9
`define ALU_OP_COPY_SRC2 4'd10
`endif

module tb_id_ex_alu_ctrl;

    typedef struct {
        bit        v;
        bit [3:0]  op;
        bit [31:0] s1;
        bit [31:0] s2;
        bit [4:0]  rd;
        bit        rw;
        bit        ill;
    } ex_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        id_valid = 1'b0;
    logic [31:0] id_instr = '0;
    logic [31:0] id_pc = '0;
    logic [31:0] id_rs1_data = '0;
    logic [31:0] id_rs2_data = '0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        ex_valid;
    logic [3:0]  ex_alu_op;
    logic [31:0] ex_src1;
    logic [31:0] ex_src2;
    logic [4:0]  ex_rd;
    logic        ex_reg_write;
    logic        ex_illegal;

    int checks = 0;
    int failures = 0;
    ex_t exp_q;

    id_ex_alu_ctrl #(.XLEN(32), .ALU_OP_WIDTH(4)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_instr(id_instr),
        .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .stall(stall), .flush(flush), .ex_valid(ex_valid), .ex_alu_op(ex_alu_op),
        .ex_src1(ex_src1), .ex_src2(ex_src2), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_illegal(ex_illegal)
    );

    always #5 clk = ~clk;

    function automatic ex_t bubble();
        ex_t b;
        b.v = 0; b.op = `ALU_OP_ADD; b.s1 = 0; b.s2 = 0; b.rd = 0; b.rw = 0; b.ill = 0;
        return b;
    endfunction

    // Reference decode straight from the ISA rules
    function automatic ex_t model(bit [31:0] ins, bit [31:0] pc, bit [31:0] r1, bit [31:0] r2);
        bit [3:0] base_ops [8];
        ex_t e;
        bit [6:0] opc = ins[6:0];
        bit [2:0] f3  = ins[14:12];
        bit [6:0] f7  = ins[31:25];
        int       i_imm = $signed(ins[31:20]);
        int       s_imm = $signed({ins[31:25], ins[11:7]});
        bit [31:0] u_imm = {ins[31:12], 12'h000};
        base_ops = '{`ALU_OP_ADD, `ALU_OP_SLL, `ALU_OP_SLT, `ALU_OP_SLTU,
                     `ALU_OP_XOR, `ALU_OP_SRL, `ALU_OP_OR, `ALU_OP_AND};
        e = bubble();
        e.v = 1; e.rd = ins[11:7]; e.rw = 1;
        if (opc == 7'h33) begin
            e.s1 = r1; e.s2 = r2;
            if (f7 == 0) e.op = base_ops[f3];
            else if (f7 == 7'h20 && f3 == 0) e.op = `ALU_OP_SUB;
            else if (f7 == 7'h20 && f3 == 5) e.op = `ALU_OP_SRA;
            else e.ill = 1;
        end else if (opc == 7'h13) begin
            e.s1 = r1; e.s2 = i_imm;
            e.op = base_ops[f3];
            if (f3 == 1 && f7 != 0) e.ill = 1;
            if (f3 == 5 && f7 == 7'h20) e.op = `ALU_OP_SRA;
            if (f3 == 5 && f7 != 0 && f7 != 7'h20) e.ill = 1;
        end else if (opc == 7'h37) begin
            e.op = `ALU_OP_COPY_SRC2; e.s2 = u_imm;
        end else if (opc == 7'h17) begin
            e.s1 = pc; e.s2 = u_imm;
        end else if (opc == 7'h6F || opc == 7'h67) begin
            e.s1 = pc; e.s2 = 4;
        end else if (opc == 7'h03) begin
            e.s1 = r1; e.s2 = i_imm;
        end else if (opc == 7'h23) begin
            e.s1 = r1; e.s2 = s_imm; e.rw = 0;
        end else if (opc == 7'h63) begin
            e.s1 = r1; e.s2 = r2; e.rw = 0;
            if (f3 < 2) e.op = `ALU_OP_SUB;
            else if (f3 == 4 || f3 == 5) e.op = `ALU_OP_SLT;
            else if (f3 >= 6) e.op = `ALU_OP_SLTU;
            else e.ill = 1;
        end else begin
            e.ill = 1;
        end
        if (e.ill) begin
            e.op = `ALU_OP_ADD; e.s1 = 0; e.s2 = 0; e.rw = 0;
        end
        if (e.rd == 0) e.rw = 0;
        return e;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one clock, update the model, then compare every output against it
    task automatic cyc();
        @(posedge clk);
        if (rst) exp_q = bubble();
        else if (flush) exp_q = bubble();
        else if (stall) exp_q = exp_q;
        else if (id_valid) exp_q = model(id_instr, id_pc, id_rs1_data, id_rs2_data);
        else exp_q = bubble();
        #1;
        chk("valid", 32'(ex_valid), 32'(exp_q.v));
        chk("alu_op", 32'(ex_alu_op), 32'(exp_q.op));
        chk("src1", ex_src1, exp_q.s1);
        chk("src2", ex_src2, exp_q.s2);
        chk("rd", 32'(ex_rd), 32'(exp_q.rd));
        chk("reg_write", 32'(ex_reg_write), 32'(exp_q.rw));
        chk("illegal", 32'(ex_illegal), 32'(exp_q.ill));
    endtask

    task automatic drive(logic v, logic [31:0] ins, logic [31:0] r1, logic [31:0] r2);
        id_valid = v; id_instr = ins; id_rs1_data = r1; id_rs2_data = r2;
        id_pc = $urandom & 32'hFFFF_FFFC;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0] opcs [10];
        logic [31:0] ins;
        opcs = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h23, 7'h63, 7'h33};
        ins = $urandom;
        case ($urandom_range(0, 9))
            0: ;
            1: begin ins[6:0] = 7'h13; ins[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00; end
            2: begin ins[6:0] = 7'h33; ins[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00; end
            default: ins[6:0] = opcs[$urandom_range(0, 9)];
        endcase
        if ($urandom_range(0, 7) == 0) ins[11:7] = 5'd0;
        return ins;
    endfunction

    initial begin
        exp_q = bubble();
        // Reset held two cycles with a valid instruction present
        rst = 1; drive(1, 32'hFFB10093, 32'd10, 32'd0);
        cyc(); cyc();
        chk("rst_op_lit", 32'(ex_alu_op), 32'(`ALU_OP_ADD));
        chk("rst_valid_lit", 32'(ex_valid), 32'd0);
        rst = 0;

        // addi x1,x2,-5
        drive(1, 32'hFFB10093, 32'd10, 32'd0);
        cyc();
        chk("addi_src1_lit", ex_src1, 32'd10);
        chk("addi_src2_lit", ex_src2, 32'hFFFF_FFFB);
        chk("addi_rd_lit", 32'(ex_rd), 32'd1);
        chk("addi_rw_lit", 32'(ex_reg_write), 32'd1);

        // sub x3,x4,x5 then srai x6,x7,3
        drive(1, 32'h405201B3, 32'd7, 32'd3);
        cyc();
        chk("sub_op_lit", 32'(ex_alu_op), 32'(`ALU_OP_SUB));
        chk("sub_rd_lit", 32'(ex_rd), 32'd3);
        drive(1, 32'h4033D313, 32'h8000_0000, 32'd0);
        cyc();
        chk("srai_op_lit", 32'(ex_alu_op), 32'(`ALU_OP_SRA));
        chk("srai_src2_lit", ex_src2, 32'h0000_0403);
        chk("srai_rd_lit", 32'(ex_rd), 32'd6);

        // lui x5,0x12345
        drive(1, 32'h123452B7, 32'd0, 32'd0);
        cyc();
        chk("lui_op_lit", 32'(ex_alu_op), 32'(`ALU_OP_COPY_SRC2));
        chk("lui_src2_lit", ex_src2, 32'h1234_5000);

        // Stall three cycles with changing ID contents, then stall+flush
        drive(1, 32'hFFB10093, 32'd10, 32'd0);
        cyc();
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            drive(1, rand_instr(), $urandom, $urandom);
            cyc();
        end
        chk("stall_src2_lit", ex_src2, 32'hFFFF_FFFB);
        chk("stall_valid_lit", 32'(ex_valid), 32'd1);
        flush = 1;
        cyc();
        chk("flush_valid_lit", 32'(ex_valid), 32'd0);
        chk("flush_rw_lit", 32'(ex_reg_write), 32'd0);
        stall = 0; flush = 0;

        // Illegal instruction then an empty ID slot
        drive(1, 32'hFFFF_FFFF, $urandom, $urandom);
        cyc();
        chk("ill_flag_lit", 32'(ex_illegal), 32'd1);
        chk("ill_valid_lit", 32'(ex_valid), 32'd1);
        chk("ill_rw_lit", 32'(ex_reg_write), 32'd0);
        drive(0, 32'h0000_0013, 32'd0, 32'd0);
        cyc();
        chk("idle_valid_lit", 32'(ex_valid), 32'd0);
        chk("idle_ill_lit", 32'(ex_illegal), 32'd0);

        // Randomized traffic with occasional stall, flush, idle and reset
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 9) != 0), rand_instr(), $urandom, $urandom);
            stall = ($urandom_range(0, 4) == 0);
            flush = ($urandom_range(0, 9) == 0);
            rst   = ($urandom_range(0, 99) == 0);
            cyc();
        end
        rst = 0; stall = 0; flush = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
